// File: rtl/cvi_stream_rx.sv
// Clocked-video-input to Avalon-ST video receiver: captures one frame per V-sync edge,
// wraps it as {header, pixels..., eop} and buffers the beats in a show-ahead FIFO.
module cvi_stream_rx #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] vid_data,
  input  logic        vid_datavalid,
  input  logic        vid_v_sync,
  input  logic        vid_h_sync,
  output logic [23:0] dout_data,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_startofpacket,
  output logic        dout_endofpacket,
  input  logic        clear_status,
  output logic        status_overflow,
  output logic        status_short_frame,
  output logic [2:0]  dbg_state,
  output logic [15:0] dbg_line_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_ACTIVE - 1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_ACTIVE = 3'd2,
    S_CLOSE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Input capture stage
  logic [23:0] pix_data_q, pix_data_d;
  logic        pix_valid_q, pix_valid_d;
  logic        vs_q, vs_d, vs_prev_q, vs_prev_d;
  logic        hs_q, hs_d, hs_prev_q, hs_prev_d;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d, short_q, short_d;
  logic [15:0]     line_cnt_q, line_cnt_d;
  logic [25:0]     mem_q [FIFO_DEPTH];

  logic        vs_edge, hs_edge, last_pix;
  logic        fifo_full, fifo_empty, push, pop;
  logic [25:0] push_data, head;
  logic        ovf_set, short_set;

  assign vs_edge    = vs_q & ~vs_prev_q;
  assign hs_edge    = hs_q & ~hs_prev_q;
  assign last_pix   = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = ~fifo_empty & dout_ready;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    pix_data_d  = vid_data;
    pix_valid_d = vid_datavalid;
    vs_d        = vid_v_sync;
    vs_prev_d   = vs_q;
    hs_d        = vid_h_sync;
    hs_prev_d   = hs_q;
  end

  // Capture FSM; only one FIFO write per cycle, so a pixel racing the header is dropped.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    push      = 1'b0;
    push_data = 26'd0;
    ovf_set   = 1'b0;
    short_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (vs_edge) state_d = S_HDR;
      end
      S_HDR: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_data = {1'b1, 1'b0, 24'h000000};
          state_d   = S_ACTIVE;
        end else if (pix_valid_q) begin
          ovf_set = 1'b1;
          state_d = S_CLOSE;
        end
      end
      S_ACTIVE: begin
        if (vs_edge) begin
          short_set = 1'b1;
          state_d   = S_CLOSE;
        end else if (pix_valid_q) begin
          if (fifo_full) begin
            ovf_set = 1'b1;
            state_d = S_CLOSE;
          end else begin
            push      = 1'b1;
            push_data = {1'b0, last_pix, pix_data_q};
            if (last_pix) begin
              state_d = S_DONE;
            end else if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      S_CLOSE: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_data = {1'b0, 1'b1, 24'h000000};
          state_d   = S_IDLE;
        end
      end
      S_DONE: begin
        if (vs_edge) state_d = S_HDR;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_HDR && state_q != S_HDR) begin
      col_d = '0;
      row_d = '0;
    end
  end

  // Full is judged before the pop, so the FSM never pushes into a full FIFO.
  always_comb begin
    wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    ovf_d      = ovf_set   | (ovf_q   & ~clear_status);
    short_d    = short_set | (short_q & ~clear_status);
    line_cnt_d = vs_edge ? 16'd0 : (hs_edge ? line_cnt_q + 16'd1 : line_cnt_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      vs_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
      hs_q        <= 1'b0;
      hs_prev_q   <= 1'b0;
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      short_q     <= 1'b0;
      line_cnt_q  <= '0;
    end else begin
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      vs_q        <= vs_d;
      vs_prev_q   <= vs_prev_d;
      hs_q        <= hs_d;
      hs_prev_q   <= hs_prev_d;
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      short_q     <= short_d;
      line_cnt_q  <= line_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  // Outputs are forced to zero when empty so stale storage never shows on the bus.
  always_comb begin
    dout_valid         = ~fifo_empty;
    dout_startofpacket = fifo_empty ? 1'b0  : head[25];
    dout_endofpacket   = fifo_empty ? 1'b0  : head[24];
    dout_data          = fifo_empty ? 24'd0 : head[23:0];
    status_overflow    = ovf_q;
    status_short_frame = short_q;
    dbg_state          = state_q;
    dbg_line_count     = line_cnt_q;
  end

endmodule

// File: tb/tb_cvi_stream_rx.sv
// Directed bench for cvi_stream_rx with a 4x2 frame and a 4-entry FIFO.
// Valid/ready: a beat transfers on a rising edge where dout_valid and dout_ready are both 1.
module tb_cvi_stream_rx;
  localparam int H = 4;
  localparam int V = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] vid_data = '0;
  logic        vid_datavalid = 1'b0;
  logic        vid_v_sync = 1'b0;
  logic        vid_h_sync = 1'b0;
  logic [23:0] dout_data;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        dout_startofpacket;
  logic        dout_endofpacket;
  logic        clear_status = 1'b0;
  logic        status_overflow;
  logic        status_short_frame;
  logic [2:0]  dbg_state;
  logic [15:0] dbg_line_count;

  int total = 0;
  int bad   = 0;
  logic [25:0] exp_q[$];
  logic [25:0] obs_q[$];
  logic [25:0] prev_beat = '0;
  logic        prev_stall = 1'b0;

  cvi_stream_rx #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .vid_data(vid_data), .vid_datavalid(vid_datavalid),
    .vid_v_sync(vid_v_sync), .vid_h_sync(vid_h_sync),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket),
    .clear_status(clear_status),
    .status_overflow(status_overflow), .status_short_frame(status_short_frame),
    .dbg_state(dbg_state), .dbg_line_count(dbg_line_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Beat capture and hold-while-stalled check, both on the falling edge.
  always @(negedge clk) begin
    if (!reset && dout_valid === 1'b1 && dout_ready === 1'b1)
      obs_q.push_back({dout_startofpacket, dout_endofpacket, dout_data});
    if (!reset && prev_stall) begin
      total++;
      if (dout_valid !== 1'b1 || {dout_startofpacket, dout_endofpacket, dout_data} !== prev_beat) begin
        bad++;
        $display("FAIL hold: got valid=%b beat=%h want valid=1 beat=%h", dout_valid,
                 {dout_startofpacket, dout_endofpacket, dout_data}, prev_beat);
      end
    end
    prev_stall = !reset && dout_valid === 1'b1 && dout_ready === 1'b0;
    prev_beat  = {dout_startofpacket, dout_endofpacket, dout_data};
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      vid_v_sync = 1'b0; vid_datavalid = 1'b0; vid_data = '0;
    end
  endtask

  // V-sync pulse, one blank cycle, then npix pixels valued base+1 .. base+npix.
  task automatic send_frame(input int base, input int npix);
    @(posedge clk); #1;
    vid_v_sync = 1'b1; vid_datavalid = 1'b0; vid_data = '0;
    @(posedge clk); #1;
    vid_v_sync = 1'b0;
    for (int i = 1; i <= npix; i++) begin
      @(posedge clk); #1;
      vid_datavalid = 1'b1; vid_data = 24'(base + i);
    end
  endtask

  task automatic exp_frame(input int base);
    exp_q.push_back({1'b1, 1'b0, 24'h000000});
    for (int i = 1; i <= H * V; i++)
      exp_q.push_back({1'b0, (i == H * V), 24'(base + i)});
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total += 6;
    if (dout_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", dout_valid); end
    if (dout_startofpacket !== 1'b0) begin bad++; $display("FAIL rst_sop: got %b want 0", dout_startofpacket); end
    if (dout_endofpacket !== 1'b0) begin bad++; $display("FAIL rst_eop: got %b want 0", dout_endofpacket); end
    if (dout_data !== 24'd0) begin bad++; $display("FAIL rst_data: got %h want 0", dout_data); end
    if ({status_overflow, status_short_frame} !== 2'b00) begin
      bad++; $display("FAIL rst_flags: got %b want 00", {status_overflow, status_short_frame});
    end
    if (dbg_state !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    dout_ready = 1'b1;
    obs_q.delete(); exp_q.delete();
    exp_frame(0);
    send_frame(0, 8);
    idle(12);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL basic_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 26'h0, exp_q[i]);
      end
    end
    total++;
    if ({status_overflow, status_short_frame} !== 2'b00) begin
      bad++; $display("FAIL basic_flags: got %b want 00", {status_overflow, status_short_frame});
    end
  endtask

  task automatic test_overflow;
    dout_ready = 1'b0;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back({1'b1, 1'b0, 24'h000000});
    exp_q.push_back({1'b0, 1'b0, 24'd1});
    exp_q.push_back({1'b0, 1'b0, 24'd2});
    exp_q.push_back({1'b0, 1'b0, 24'd3});
    exp_q.push_back({1'b0, 1'b1, 24'h000000});
    send_frame(0, 8);
    idle(5);
    @(negedge clk);
    total += 2;
    if (status_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", status_overflow); end
    if (dout_startofpacket !== 1'b1) begin bad++; $display("FAIL ovf_head_sop: got %b want 1", dout_startofpacket); end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    idle(12);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL ovf_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL ovf_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 26'h0, exp_q[i]);
      end
    end
    total++;
    if (status_short_frame !== 1'b0) begin bad++; $display("FAIL ovf_short: got %b want 0", status_short_frame); end
  endtask

  task automatic test_short_frame;
    dout_ready = 1'b1;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back({1'b1, 1'b0, 24'h000000});
    for (int i = 1; i <= 5; i++) exp_q.push_back({1'b0, 1'b0, 24'(i)});
    exp_q.push_back({1'b0, 1'b1, 24'h000000});
    send_frame(0, 5);
    send_frame(100, 8);
    idle(12);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL short_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL short_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 26'h0, exp_q[i]);
      end
    end
    total += 2;
    if (status_short_frame !== 1'b1) begin bad++; $display("FAIL short_flag: got %b want 1", status_short_frame); end
    if (status_overflow !== 1'b1) begin bad++; $display("FAIL short_ovf_sticky: got %b want 1", status_overflow); end
  endtask

  task automatic test_clear;
    @(posedge clk); #1;
    clear_status = 1'b1;
    @(posedge clk); #1;
    clear_status = 1'b0;
    @(negedge clk);
    total++;
    if ({status_overflow, status_short_frame} !== 2'b00) begin
      bad++; $display("FAIL clear_flags: got %b want 00", {status_overflow, status_short_frame});
    end
  endtask

  task automatic test_back_to_back;
    dout_ready = 1'b1;
    obs_q.delete(); exp_q.delete();
    exp_frame(0);
    exp_frame(8);
    send_frame(0, 8);
    send_frame(8, 8);
    idle(12);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 26'h0, exp_q[i]);
      end
    end
    total++;
    if ({status_overflow, status_short_frame} !== 2'b00) begin
      bad++; $display("FAIL b2b_flags: got %b want 00", {status_overflow, status_short_frame});
    end
  endtask

  task automatic test_stall;
    dout_ready = 1'b1;
    obs_q.delete(); exp_q.delete();
    exp_frame(40);
    fork
      send_frame(40, 8);
      begin
        repeat (6) @(posedge clk);
        #1 dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 dout_ready = 1'b1;
      end
    join
    idle(12);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL stall_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL stall_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 26'h0, exp_q[i]);
      end
    end
    total++;
    if (status_overflow !== 1'b0) begin bad++; $display("FAIL stall_ovf: got %b want 0", status_overflow); end
  endtask

  task automatic test_reset_mid;
    dout_ready = 1'b0;
    send_frame(0, 3);
    idle(2);
    @(negedge clk);
    total++;
    if (dout_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid: got %b want 1", dout_valid); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (dout_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", dout_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    dout_ready = 1'b1;
    obs_q.delete(); exp_q.delete();
    idle(3);
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL midrst_leftover: got %0d beats want 0", obs_q.size()); end
    exp_frame(20);
    send_frame(20, 8);
    idle(12);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL midrst_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL midrst_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 26'h0, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_short_frame();
    test_clear();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
